// File: rtl/calc_ctrl.sv
// -----------------------------------------------------------------------------
// calc_ctrl
//
// Sequencer for the button calculator datapath. It conditions the execute and
// clear push buttons into single-cycle press pulses, launches one ALU operation
// per execute press, waits out the ALU latency and writes the result back into
// the accumulator (which also drives the LEDs).
//
// Optional build macro: CALC_DEBOUNCE_EN
//   Defined   -> each synchronised button needs DEB_CYCLES consecutive equal
//                samples before its conditioned level changes.
//   Undefined -> conditioned level is the synchronised level; no debounce
//                counters exist.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   btnd          raw execute button (asynchronous)
//   btnu          raw clear-accumulator button (asynchronous)
//   op_code[3:0]  operation from the button encoder
//   sw            operand B switches (sign-extended to DATA_WIDTH)
//   alu_op[3:0]   registered operation presented to the ALU
//   alu_a         operand A, always the accumulator
//   alu_b         operand B, sign-extended sw captured at launch
//   alu_result    ALU result, valid ALU_LAT cycles after operands are driven
//   led           accumulator bits [SW_WIDTH-1:0]
//   busy          high while an operation is in flight
//   result_valid  one-cycle pulse when the accumulator takes an ALU result
// -----------------------------------------------------------------------------
module calc_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int SW_WIDTH   = 16,
    parameter int ALU_LAT    = 1,
    parameter int DEB_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btnd,
    input  logic                  btnu,
    input  logic [3:0]            op_code,
    input  logic [SW_WIDTH-1:0]   sw,
    output logic [3:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic [SW_WIDTH-1:0]   led,
    output logic                  busy,
    output logic                  result_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    // Catch nonsensical parameter sets at elaboration time.
    if (ALU_LAT < 1 || DEB_CYCLES < 1 || SW_WIDTH > DATA_WIDTH) begin : g_param_check
        $error("calc_ctrl: illegal parameter combination");
    end

    // -------------------------------------------------------------------------
    // Button path: bit 0 = execute (btnd), bit 1 = clear (btnu)
    // -------------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] level;              // conditioned button level
    logic [1:0] level_prev_q, level_prev_d;
    logic [1:0] press_p;
    logic       exe_p;
    logic       clr_p;

    assign btn_raw = {btnu, btnd};

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        level_prev_d = level;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_prev_q <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_prev_q <= level_prev_d;
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic [DEB_W-1:0] cnt_q, cnt_d;
            logic             deb_q, deb_d;

            // The counter tracks how many consecutive samples have disagreed
            // with the current level; any agreeing sample restarts the count.
            always_comb begin
                cnt_d = cnt_q;
                deb_d = deb_q;
                if (sync2_q[gi] == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_d = sync2_q[gi];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    deb_q <= deb_d;
                end
            end

            assign level[gi] = deb_q;
        end
    endgenerate
`else
    assign level = sync2_q;
`endif

    // Rising edge of the conditioned level: one pulse per press, however long held.
    assign press_p = level & ~level_prev_q;
    assign exe_p   = press_p[0];
    assign clr_p   = press_p[1];

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  rv_q, rv_d;
    logic [DATA_WIDTH-1:0] sw_sext;

    assign sw_sext = DATA_WIDTH'($signed(sw));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        op_d    = op_q;
        b_d     = b_q;
        rv_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Clear outranks execute when both arrive together.
                if (clr_p) begin
                    acc_d = '0;
                end else if (exe_p) begin
                    op_d    = op_code;
                    b_d     = sw_sext;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (clr_p) begin
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ALU_LAT - 1)) begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                // An abort on the write-back cycle discards the result.
                if (clr_p) begin
                    acc_d = '0;
                end else begin
                    acc_d = alu_result;
                    rv_d  = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            b_q     <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            b_q     <= b_d;
            rv_q    <= rv_d;
        end
    end

    assign alu_op       = op_q;
    assign alu_a        = acc_q;
    assign alu_b        = b_q;
    assign led          = acc_q[SW_WIDTH-1:0];
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = rv_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calc_ctrl
//
// Three calc_ctrl instances (ALU latency 1, 3 and 16) share the same button,
// op_code and sw stimulus; each has its own pipelined ALU model. A reference
// model computes the expected outputs every cycle from the button-timing and
// operation rules, and directed table vectors plus hand-written sequences
// check the main functions and corner cases.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_calc_ctrl;

    localparam int DW  = 32;
    localparam int SWW = 16;
    localparam int DEB = 4;
    localparam int NI  = 3;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 16);
    endfunction

    function automatic logic [DW-1:0] alu_f(input logic [3:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            default: return a ^ b;
        endcase
    endfunction

    logic clk = 1'b0;
    logic reset;
    logic btnd;
    logic btnu;
    logic [3:0]     op_code;
    logic [SWW-1:0] sw;

    logic [NI-1:0][3:0]     alu_op_w;
    logic [NI-1:0][DW-1:0]  alu_a_w;
    logic [NI-1:0][DW-1:0]  alu_b_w;
    logic [NI-1:0][DW-1:0]  alu_res_w;
    logic [NI-1:0][SWW-1:0] led_w;
    logic [NI-1:0]          busy_w;
    logic [NI-1:0]          rv_w;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_inst
            localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 3 : 16);
            logic [DW-1:0] pipe [L];

            calc_ctrl #(
                .DATA_WIDTH(DW),
                .SW_WIDTH  (SWW),
                .ALU_LAT   (L),
                .DEB_CYCLES(DEB)
            ) u_dut (
                .clk         (clk),
                .reset       (reset),
                .btnd        (btnd),
                .btnu        (btnu),
                .op_code     (op_code),
                .sw          (sw),
                .alu_op      (alu_op_w[gi]),
                .alu_a       (alu_a_w[gi]),
                .alu_b       (alu_b_w[gi]),
                .alu_result  (alu_res_w[gi]),
                .led         (led_w[gi]),
                .busy        (busy_w[gi]),
                .result_valid(rv_w[gi])
            );

            // ALU with L register stages
            always @(posedge clk) begin
                pipe[0] <= alu_f(alu_op_w[gi], alu_a_w[gi], alu_b_w[gi]);
                for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
            end
            assign alu_res_w[gi] = pipe[L-1];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Check bookkeeping
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model (updated at each rising edge)
    // -------------------------------------------------------------------------
    logic           raw_now [2];
    logic           raw_last[2];
    logic           y_m     [2];   // synchronised level
    logic           d_m     [2];   // conditioned level
    logic           dp_m    [2];   // conditioned level one cycle earlier
    logic [DEB-1:0] yh_m    [2];   // recent synchronised samples
    logic [DW-1:0]  m_acc [NI];
    logic [DW-1:0]  m_b   [NI];
    logic [DW-1:0]  m_res [NI];
    logic [3:0]     m_op  [NI];
    logic           m_busy[NI];
    logic           m_rv  [NI];
    int             m_done[NI];
    int             cyc = 0;
    logic           exe_m, clr_m;

    always @(posedge clk) begin
        exe_m = d_m[0] & ~dp_m[0];
        clr_m = d_m[1] & ~dp_m[1];
        raw_now[0] = btnd;
        raw_now[1] = btnu;
        if (reset) begin
            for (int i = 0; i < NI; i++) begin
                m_acc[i] = '0; m_b[i] = '0; m_res[i] = '0; m_op[i] = '0;
                m_busy[i] = 1'b0; m_rv[i] = 1'b0; m_done[i] = 0;
            end
            for (int b = 0; b < 2; b++) begin
                raw_last[b] = 1'b0; y_m[b] = 1'b0; d_m[b] = 1'b0;
                dp_m[b] = 1'b0; yh_m[b] = '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                m_rv[i] = 1'b0;
                if (m_busy[i]) begin
                    if (clr_m) begin
                        m_acc[i]  = '0;
                        m_busy[i] = 1'b0;
                    end else if (cyc == m_done[i]) begin
                        m_acc[i]  = m_res[i];
                        m_rv[i]   = 1'b1;
                        m_busy[i] = 1'b0;
                    end
                end else if (clr_m) begin
                    m_acc[i] = '0;
                end else if (exe_m) begin
                    m_op[i]   = op_code;
                    m_b[i]    = {{(DW-SWW){sw[SWW-1]}}, sw};
                    m_res[i]  = alu_f(op_code, m_acc[i], m_b[i]);
                    m_busy[i] = 1'b1;
                    m_done[i] = cyc + lat_of(i) + 1;
                end
            end
            for (int b = 0; b < 2; b++) begin
`ifdef CALC_DEBOUNCE_EN
                yh_m[b] = {yh_m[b][DEB-2:0], y_m[b]};
                dp_m[b] = d_m[b];
                if (yh_m[b] == {DEB{~d_m[b]}}) d_m[b] = ~d_m[b];
`else
                dp_m[b] = d_m[b];
                d_m[b]  = raw_last[b];
`endif
                y_m[b]      = raw_last[b];
                raw_last[b] = raw_now[b];
            end
        end
        cyc++;
    end

    // -------------------------------------------------------------------------
    // Per-cycle comparison against the model
    // -------------------------------------------------------------------------
    logic mon_en = 1'b0;
    int   rv_cnt  [NI];
    int   busy_cnt[NI];

    initial begin
        for (int i = 0; i < NI; i++) begin rv_cnt[i] = 0; busy_cnt[i] = 0; end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("m%0d acc", i),  alu_a_w[i], m_acc[i]);
                chk($sformatf("m%0d led", i),  DW'(led_w[i]), DW'(m_acc[i][SWW-1:0]));
                chk($sformatf("m%0d busy", i), DW'(busy_w[i]), DW'(m_busy[i]));
                chk($sformatf("m%0d rv", i),   DW'(rv_w[i]), DW'(m_rv[i]));
                chk($sformatf("m%0d op", i),   DW'(alu_op_w[i]), DW'(m_op[i]));
                chk($sformatf("m%0d b", i),    alu_b_w[i], m_b[i]);
                if (rv_w[i] === 1'b1)   rv_cnt[i]++;
                if (busy_w[i] === 1'b1) busy_cnt[i]++;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    typedef struct {
        logic [3:0]     op;
        logic [SWW-1:0] swv;
        logic [DW-1:0]  exp_b;
        logic [DW-1:0]  exp_acc;
    } vec_t;

    vec_t vt [8];
    int   rv_snap  [NI];
    int   busy_snap[NI];

    task automatic snap();
        for (int i = 0; i < NI; i++) begin rv_snap[i] = rv_cnt[i]; busy_snap[i] = busy_cnt[i]; end
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    // which: 1 = btnd, 2 = btnu, 3 = both
    task automatic press(input int which, input int hi, input int lo);
        if (which[0]) btnd = 1'b1;
        if (which[1]) btnu = 1'b1;
        repeat (hi) @(negedge clk);
        btnd = 1'b0;
        btnu = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [DW-1:0] acc, input int d0, input int d1, input int d2);
        int exp_d [NI];
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2;
        settle();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s i%0d acc", tag, i), alu_a_w[i], acc);
            chk($sformatf("%s i%0d led", tag, i), DW'(led_w[i]), DW'(acc[SWW-1:0]));
            chk($sformatf("%s i%0d busy", tag, i), DW'(busy_w[i]), '0);
            chk($sformatf("%s i%0d rv count", tag, i), DW'(rv_cnt[i] - rv_snap[i]), DW'(exp_d[i]));
        end
    endtask

    initial begin
        vt[0] = '{4'b0010, 16'h0005, 32'h0000_0005, 32'h0000_0005};
        vt[1] = '{4'b0010, 16'h0003, 32'h0000_0003, 32'h0000_0008};
        vt[2] = '{4'b0111, 16'h0001, 32'h0000_0001, 32'h0000_0001};
        vt[3] = '{4'b0010, 16'hFFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vt[4] = '{4'b0110, 16'h0002, 32'h0000_0002, 32'hFFFF_FFFE};
        vt[5] = '{4'b0001, 16'h00F0, 32'h0000_00F0, 32'hFFFF_FFFE};
        vt[6] = '{4'b0000, 16'h8001, 32'hFFFF_8001, 32'hFFFF_8000};
        vt[7] = '{4'b0101, 16'h7FFF, 32'h0000_7FFF, 32'hFFFF_FFFF};

        reset = 1'b1; btnd = 1'b0; btnu = 1'b0; op_code = 4'h0; sw = '0;
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            settle();
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("idle i%0d acc", i), alu_a_w[i], '0);
                chk($sformatf("idle i%0d led", i), DW'(led_w[i]), '0);
                chk($sformatf("idle i%0d busy", i), DW'(busy_w[i]), '0);
                chk($sformatf("idle i%0d rv", i), DW'(rv_w[i]), '0);
                chk($sformatf("idle i%0d op", i), DW'(alu_op_w[i]), '0);
            end
        end

        // Table vectors
        for (int v = 0; v < 8; v++) begin
            op_code = vt[v].op;
            sw      = vt[v].swv;
            snap();
            press(1, 8, 24);
            chk_all($sformatf("vec%0d", v), vt[v].exp_acc, 1, 1, 1);
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("vec%0d i%0d alu_b", v, i), alu_b_w[i], vt[v].exp_b);
                chk($sformatf("vec%0d i%0d alu_op", v, i), DW'(alu_op_w[i]), DW'(vt[v].op));
            end
            $display("vec %0d: op=%b sw=%h -> acc=%h led=%h", v, vt[v].op, vt[v].swv, alu_a_w[0], led_w[0]);
        end

        // Held button: one operation only
        op_code = 4'b0111; sw = 16'h0042;
        snap();
        press(1, 20, 30);
        chk_all("hold", 32'h42, 1, 1, 1);
        $display("hold: 20-cycle btnd -> acc=%h", alu_a_w[0]);

        // Second press while busy is dropped on the long-latency instance only
        op_code = 4'b0111; sw = 16'h0099;
        snap();
        press(1, 5, 5);
        press(1, 5, 40);
        chk_all("drop", 32'h99, 2, 2, 1);
        $display("drop: double press -> results %0d/%0d/%0d", rv_cnt[0]-rv_snap[0], rv_cnt[1]-rv_snap[1], rv_cnt[2]-rv_snap[2]);

        // Coincident clear and execute: clear wins, nothing launched
        snap();
        press(3, 8, 24);
        chk_all("coincident", 32'h0, 0, 0, 0);
        for (int i = 0; i < NI; i++)
            chk($sformatf("coincident i%0d busy cycles", i), DW'(busy_cnt[i] - busy_snap[i]), '0);
        $display("coincident: btnd+btnu -> acc=%h", alu_a_w[0]);

        // Clear during execution aborts the long-latency operation
        op_code = 4'b0111; sw = 16'h0077;
        snap();
        btnd = 1'b1;
        repeat (6) @(negedge clk);
        btnd = 1'b0;
        press(2, 6, 30);
        chk_all("abort", 32'h0, 1, 1, 0);
        $display("abort: btnu during EXEC -> acc=%h", alu_a_w[2]);

        // Reset while executing
        op_code = 4'b0111; sw = 16'h0055;
        press(1, 8, 0);
        reset = 1'b1;
        settle();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst i%0d acc", i), alu_a_w[i], '0);
            chk($sformatf("rst i%0d led", i), DW'(led_w[i]), '0);
            chk($sformatf("rst i%0d busy", i), DW'(busy_w[i]), '0);
            chk($sformatf("rst i%0d rv", i), DW'(rv_w[i]), '0);
            chk($sformatf("rst i%0d op", i), DW'(alu_op_w[i]), '0);
            chk($sformatf("rst i%0d b", i), alu_b_w[i], '0);
        end
        reset = 1'b0;
        repeat (30) @(negedge clk);
        $display("reset mid-op: outputs back to reset values");

`ifdef CALC_DEBOUNCE_EN
        // Short glitch is filtered, a longer press is taken once
        op_code = 4'b0010; sw = 16'h0001;
        snap();
        press(1, 2, 30);
        chk_all("glitch", 32'h0, 0, 0, 0);
        $display("glitch: 2-cycle btnd ignored");
        snap();
        press(1, 6, 30);
        chk_all("press6", 32'h1, 1, 1, 1);
        $display("press6: 6-cycle btnd -> acc=%h", alu_a_w[0]);
`endif

        // Randomised traffic, checked against the model every cycle
        for (int t = 0; t < 150; t++) begin
            int run;
            run     = int'($urandom_range(1, 9));
            btnd    = 1'($urandom_range(0, 1));
            btnu    = ($urandom_range(0, 4) == 0);
            op_code = 4'($urandom);
            sw      = 16'($urandom);
            reset   = ($urandom_range(0, 50) == 0);
            @(negedge clk);
            reset = 1'b0;
            repeat (run) begin
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) begin
                    op_code = 4'($urandom);
                    sw      = 16'($urandom);
                end
            end
            if (t % 25 == 0)
                $display("random burst %0d: acc=%h/%h/%h", t, alu_a_w[0], alu_a_w[1], alu_a_w[2]);
        end
        btnd = 1'b0;
        btnu = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
Sequencer for the button calculator datapath.
- Conditions the push buttons and registers the 4-bit operation code from the button encoder.
- Drives the shared ALU with accumulator and switch operands, waits out the ALU latency, and writes the result back into the accumulator and LEDs.
- Sits between the board I/O (buttons, switches, LEDs) and the ALU/encoder pair.

Parameters:
- DATA_WIDTH, 32, ALU operand/result and accumulator width.
- SW_WIDTH, 16, switch input width; LED output width; must be <= DATA_WIDTH.
- ALU_LAT, 1, cycles from operand drive to valid alu_result (>= 1).
- DEB_CYCLES, 4, debounce stability count (used only with CALC_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- btnd  in  1  raw "execute" button, asynchronous to clk.
- btnu  in  1  raw "clear accumulator" button, asynchronous to clk.
- op_code  in  4  ALU operation from the button encoder (combinational from btnl/btnc/btnr).
- sw  in  SW_WIDTH  operand B switches, sign-extended to DATA_WIDTH.
- alu_op  out  4  registered operation presented to the ALU.
- alu_a  out  DATA_WIDTH  operand A (accumulator).
- alu_b  out  DATA_WIDTH  operand B (sign-extended sw, captured at launch).
- alu_result  in  DATA_WIDTH  ALU result.
- led  out  SW_WIDTH  accumulator bits [SW_WIDTH-1:0].
- busy  out  1  high while an operation is in flight.
- result_valid  out  1  one-cycle pulse when the accumulator is updated.

Behaviour:
- Reset (synchronous, highest priority, any state):
  - acc=0, alu_op=0, alu_b=0, led=0, busy=0, result_valid=0.
  - State=IDLE; latency counter=0.
  - Button synchronisers and debouncers cleared to "released".
- Button path:
  - btnd and btnu each pass through a 2-flop synchroniser, then conditioning, then a rising-edge detect.
  - The result is a single-cycle press pulse: exe_p for btnd, clr_p for btnu.
  - A held button produces exactly one pulse.
- alu_a is continuously acc.
- State machine:
  - IDLE (busy=0):
    - clr_p: acc<=0, led<=0, stay IDLE; clr_p wins if coincident with exe_p.
    - else exe_p: alu_op<=op_code, alu_b<=sext(sw), counter<=0, go EXEC.
  - EXEC (busy=1): counter increments each cycle; when counter==ALU_LAT-1, go WB.
  - WB (busy=1):
    - acc<=alu_result, led<=alu_result[SW_WIDTH-1:0], result_valid<=1 for exactly this transition.
    - Go IDLE.
- Latency: exe_p to result_valid = ALU_LAT+1 cycles. acc, led and result_valid all update on the same edge.
- Operation registers:
  - alu_op and alu_b hold their launched values through EXEC/WB and until the next launch.
  - op_code/sw changes mid-operation have no effect.
- Abort: clr_p in EXEC or WB aborts the operation.
  - acc<=0, led<=0, go IDLE, result_valid stays 0.
  - clr_p takes priority over the WB update on the same cycle.
- exe_p while busy is dropped, not queued.
- Arithmetic: acc takes alu_result verbatim. Overflow/wrap is defined by the ALU; the controller adds no flag.
- Sign extension: sw[SW_WIDTH-1] replicated into alu_b[DATA_WIDTH-1:SW_WIDTH].

Optional Feature:
CALC_DEBOUNCE_EN
- Defined:
  - Each synchronised button needs DEB_CYCLES consecutive equal samples before its debounced level changes.
  - Glitches shorter than DEB_CYCLES are ignored.
  - exe_p/clr_p fire DEB_CYCLES cycles after the raw press, plus synchroniser delay.
  - A new press is only recognised after a stable release of DEB_CYCLES cycles.
- Undefined: debounced level = synchronised level; the debounce counters are not instantiated.

Test Plan:
- Reset then idle:
  - reset=1 for 2 cycles, all buttons low.
  - Expect acc=0, led=0, busy=0, result_valid=0, alu_op=0 for 10 cycles.
- Single add (bench ALU model: 4'b0010 = A+B, ALU_LAT=1):
  - op_code=4'b0010, sw=16'h0005, pulse btnd.
  - Expect result_valid exactly once; acc=32'h5, led=16'h0005.
  - Repeat with sw=16'h0003: expect acc=32'h8.
- Sign extension and wrap:
  - acc=32'h1, op 4'b0010, sw=16'hFFFF.
  - Expect alu_b=32'hFFFF_FFFF; acc=32'h0, led=16'h0000.
- Hold and busy drop:
  - ALU_LAT=3; hold btnd high 20 cycles.
  - Expect one operation and one result_valid.
  - A second btnd press during busy gives no extra result_valid.
- Clear priority and abort:
  - btnd and btnu pressed on the same edge: acc=0, no EXEC entry.
  - btnu during EXEC: busy falls, acc=0, result_valid never asserts.
- Reset mid-operation and debounce:
  - reset asserted in EXEC: next cycle IDLE, all outputs at reset values.
  - With CALC_DEBOUNCE_EN and DEB_CYCLES=4: a 2-cycle btnd glitch produces no operation; a 6-cycle press produces exactly one.
